// File: rtl/twiddle_seq_gen.sv
// Streams the N/2 radix-2 DIT twiddles W_N^k of one FFT stage, folded from a quarter-wave cosine ROM; first out_valid 2 clk after start.
// out_valid & ~out_ready freezes the whole pipe and the j counter; define TF_INV_EN to add the inv (conjugate/IFFT) port.
module twiddle_seq_gen #(
    parameter int LOG2N = 8,
    parameter int WIDTH = 20,
    parameter int FRAC  = 18,
    localparam int SW   = $clog2(LOG2N)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [SW-1:0]           stage,
`ifdef TF_INV_EN
    input  logic                    inv,
`endif
    input  logic                    out_ready,
    output logic                    out_valid,
    output logic signed [WIDTH-1:0] out_real,
    output logic signed [WIDTH-1:0] out_imag,
    output logic [LOG2N-2:0]        out_index,
    output logic                    out_last,
    output logic                    busy
);

    localparam int JW = LOG2N - 1;
    localparam int RN = 1 << JW;
    localparam int Q  = 1 << (LOG2N - 2);

    if (LOG2N < 3 || LOG2N > 12) begin : g_bad_log2n
        $error("twiddle_seq_gen: LOG2N must be 3..12");
    end
    if (WIDTH < FRAC + 2) begin : g_bad_width
        $error("twiddle_seq_gen: WIDTH must be at least FRAC+2");
    end

    // Elaboration-time cosine via Taylor series; argument stays within [0, pi/2].
    function automatic int rom_val(input int m);
        real x, term, sum, scale;
        x     = 6.283185307179586 * real'(m) / real'(1 << LOG2N);
        term  = 1.0;
        sum   = 1.0;
        scale = 1.0;
        for (int n = 1; n < 16; n++) begin
            term = -term * x * x / real'((2 * n - 1) * (2 * n));
            sum  = sum + term;
        end
        for (int b = 0; b < FRAC; b++) scale = scale * 2.0;
        return $rtoi(sum * scale + 0.5);
    endfunction

    logic [FRAC:0] rom [RN];
    for (genvar m = 0; m < RN; m++) begin : g_rom
        localparam int CV = (m <= Q) ? rom_val(m) : 0;
        assign rom[m] = CV[FRAC:0];
    end

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state;
    logic [SW-1:0]   s_q;
    logic [JW-1:0]   j;
    logic            iss;
    logic            v1;
    logic [FRAC:0]   a1, b1;
    logic            neg1, last1;
    logic [JW-1:0]   idx1;
`ifdef TF_INV_EN
    logic            inv_q;
`endif

    logic [JW-1:0]   mask, k, a_idx, b_idx;
    logic [SW-1:0]   shamt;
    logic            adv;
    logic signed [WIDTH-1:0] re_mag, im_mag;

    assign busy = (state == RUN);
    assign adv  = !(out_valid && !out_ready);

    // Second half of the half-wave mirrors the cosine and shifts the sine index by N/4.
    always_comb begin
        mask   = (JW'(1) << s_q) - JW'(1);
        shamt  = SW'(JW) - s_q;
        k      = (j & mask) << shamt;
        a_idx  = k[JW-1] ? (JW'(0) - k) : k;
        b_idx  = k[JW-1] ? (k - JW'(Q)) : (JW'(Q) - k);
        re_mag = {{(WIDTH - FRAC - 1){1'b0}}, a1};
        im_mag = {{(WIDTH - FRAC - 1){1'b0}}, b1};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            s_q       <= '0;
            j         <= '0;
            iss       <= 1'b0;
            v1        <= 1'b0;
            a1        <= '0;
            b1        <= '0;
            neg1      <= 1'b0;
            idx1      <= '0;
            last1     <= 1'b0;
            out_valid <= 1'b0;
            out_real  <= '0;
            out_imag  <= '0;
            out_index <= '0;
            out_last  <= 1'b0;
`ifdef TF_INV_EN
            inv_q     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (start) begin
                    state <= RUN;
                    s_q   <= (int'(stage) >= LOG2N) ? SW'(JW) : stage;
                    j     <= '0;
                    iss   <= 1'b1;
`ifdef TF_INV_EN
                    inv_q <= inv;
`endif
                end
                RUN: if (out_valid && out_ready && out_last) state <= IDLE;
                default: state <= IDLE;
            endcase

            if (adv) begin
                v1    <= iss;
                a1    <= rom[a_idx];
                b1    <= rom[b_idx];
                neg1  <= k[JW-1];
                idx1  <= j;
                last1 <= &j;
                if (iss) begin
                    j <= j + 1'b1;
                    if (&j) iss <= 1'b0;
                end

                out_valid <= v1;
                out_real  <= neg1 ? -re_mag : re_mag;
`ifdef TF_INV_EN
                out_imag  <= inv_q ? im_mag : -im_mag;
`else
                out_imag  <= -im_mag;
`endif
                out_index <= idx1;
                out_last  <= v1 && last1;
            end
        end
    end

endmodule

// File: tb/tb_twiddle_seq_gen.sv
// Bench for twiddle_seq_gen: spec vectors, full-sequence model checks, backpressure, restart/abort cases.
module tb_twiddle_seq_gen;
    localparam int LOG2N = 8;
    localparam int FRAC  = 18;
    localparam int NH    = 128;

    logic clk = 1'b0;
    logic rst, start, out_ready, out_valid, out_last, busy;
    logic [2:0] stage;
    logic signed [19:0] out_real, out_imag;
    logic [6:0] out_index;
`ifdef TF_INV_EN
    logic inv;
`endif

    logic start4, out_ready4, out_valid4, out_last4, busy4;
    logic [1:0] stage4;
    logic signed [19:0] out_real4, out_imag4;
    logic [2:0] out_index4;

    always #5 clk = ~clk;

    twiddle_seq_gen dut (
        .clk(clk), .rst(rst), .start(start), .stage(stage),
`ifdef TF_INV_EN
        .inv(inv),
`endif
        .out_ready(out_ready), .out_valid(out_valid), .out_real(out_real),
        .out_imag(out_imag), .out_index(out_index), .out_last(out_last), .busy(busy)
    );

    twiddle_seq_gen #(.LOG2N(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .stage(stage4),
`ifdef TF_INV_EN
        .inv(1'b0),
`endif
        .out_ready(out_ready4), .out_valid(out_valid4), .out_real(out_real4),
        .out_imag(out_imag4), .out_index(out_index4), .out_last(out_last4), .busy(busy4)
    );

    int tests = 0;
    int fails = 0;
    int rec_re[NH], rec_im[NH], rec_idx[NH], rec_last[NH];
    int rec_n;

    typedef struct {
        int s;
        int j;
        int re;
        int im;
        int last;
    } vec_t;

    task automatic check(input string name, input longint got, input longint exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endtask

    function automatic int rnd(input real x);
        return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
    endfunction

    // Reference: W_N^k = cos(2*pi*k/N) - j*sin(2*pi*k/N), scaled and rounded.
    task automatic model(input int s, input int j, input bit iv, output int re, output int im);
        int sc, k;
        real ang;
        sc  = (s >= LOG2N) ? LOG2N - 1 : s;
        k   = (j % (1 << sc)) * (1 << (LOG2N - 1 - sc));
        ang = 2.0 * 3.141592653589793 * real'(k) / real'(1 << LOG2N);
        re  = rnd($cos(ang) * real'(1 << FRAC));
        im  = -rnd($sin(ang) * real'(1 << FRAC));
        if (iv) im = -im;
    endtask

    task automatic run_seq(input int s, input int rdy_pct, input bit iv, input bit hold_start);
        int cyc, lat, h_re, h_im, h_idx;
        bit stalled, done;
        @(negedge clk);
        start = 1'b1;
        stage = 3'(s);
`ifdef TF_INV_EN
        inv = iv;
`else
        if (iv) $display("inv requested without TF_INV_EN; ignored");
`endif
        rec_n = 0; lat = 0; cyc = 0; stalled = 0; done = 0;
        h_re = 0; h_im = 0; h_idx = 0;
        while (!done && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (!hold_start) start = 1'b0;
            if (cyc == 1) check("busy_after_start", busy, 1);
            if (out_valid && lat == 0) lat = cyc;
            if (stalled)
                check("hold_stable", (out_valid && out_real == h_re && out_imag == h_im
                                      && out_index == h_idx), 1);
            if (out_valid) begin
                out_ready = ($urandom_range(0, 99) < rdy_pct);
                if (out_ready) begin
                    stalled = 0;
                    if (rec_n >= NH) begin
                        check("extra_output", rec_n, NH - 1);
                        done = 1;
                    end else begin
                        rec_re[rec_n]   = out_real;
                        rec_im[rec_n]   = out_imag;
                        rec_idx[rec_n]  = out_index;
                        rec_last[rec_n] = out_last;
                        check("index_order", out_index, rec_n);
                        check("last_flag", out_last, (rec_n == NH - 1));
                        rec_n++;
                        if (out_last) done = 1;
                    end
                end else begin
                    stalled = 1;
                    h_re = out_real; h_im = out_imag; h_idx = out_index;
                end
            end else begin
                out_ready = 1'($urandom_range(0, 1));
                stalled = 0;
            end
        end
        start = 1'b0;
        check("seq_timeout", done, 1);
        @(negedge clk);
        check("busy_drop", busy, 0);
        check("valid_drop", out_valid, 0);
        check("count", rec_n, NH);
        check("first_latency", lat, 3);
        if (hold_start) begin
            int seen = 0;
            repeat (6) begin
                @(negedge clk);
                if (out_valid || busy) seen++;
            end
            check("no_restart", seen, 0);
        end
    endtask

    task automatic verify_all(input int s, input bit iv);
        int er, ei;
        for (int j = 0; j < rec_n; j++) begin
            model(s, j, iv, er, ei);
            check($sformatf("re s=%0d j=%0d", s, j), rec_re[j], er);
            check($sformatf("im s=%0d j=%0d", s, j), rec_im[j], ei);
        end
    endtask

    initial begin
        vec_t vt[8];
        int found, cyc, seen, s;
        vt[0] = '{7, 0, 262144, 0, 0};
        vt[1] = '{7, 1, 262065, -6433, 0};
        vt[2] = '{7, 64, 0, -262144, 0};
        vt[3] = '{7, 127, -262065, -6433, 1};
        vt[4] = '{7, 32, 185364, -185364, 0};
        vt[5] = '{0, 77, 262144, 0, 0};
        vt[6] = '{1, 3, 0, -262144, 0};
        vt[7] = '{1, 2, 262144, 0, 0};

        rst = 1'b1; start = 1'b0; stage = '0; out_ready = 1'b0;
        start4 = 1'b0; stage4 = '0; out_ready4 = 1'b1;
`ifdef TF_INV_EN
        inv = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check("rst_valid", out_valid, 0);
        check("rst_real", out_real, 0);
        check("rst_imag", out_imag, 0);
        check("rst_index", out_index, 0);
        check("rst_last", out_last, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_seq(vt[i].s, 100, 0, 0);
            check($sformatf("vec%0d_re", i), rec_re[vt[i].j], vt[i].re);
            check($sformatf("vec%0d_im", i), rec_im[vt[i].j], vt[i].im);
            check($sformatf("vec%0d_last", i), rec_last[vt[i].j], vt[i].last);
            check($sformatf("vec%0d_idx", i), rec_idx[vt[i].j], vt[i].j);
        end

        run_seq(7, 100, 0, 0); verify_all(7, 0);
        run_seq(0, 100, 0, 0); verify_all(0, 0);
        run_seq(7, 50, 0, 0);  verify_all(7, 0);
        run_seq(7, 70, 0, 1);  verify_all(7, 0);

        // Abort at j=40 with an asynchronous reset pulse.
        @(negedge clk);
        start = 1'b1; stage = 3'd7; out_ready = 1'b1;
        found = 0; cyc = 0;
        while (!found && cyc < 500) begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (out_valid && out_index == 7'd40) found = 1;
        end
        check("reach_j40", found, 1);
        rst = 1'b1;
        #1;
        check("abort_valid", out_valid, 0);
        check("abort_real", out_real, 0);
        check("abort_imag", out_imag, 0);
        check("abort_index", out_index, 0);
        check("abort_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("abort_silent", seen, 0);
        run_seq(7, 100, 0, 0); verify_all(7, 0);

        for (int r = 0; r < 4; r++) begin
            s = $urandom_range(0, 7);
            run_seq(s, $urandom_range(30, 100), 0, 0);
            verify_all(s, 0);
        end

`ifdef TF_INV_EN
        run_seq(7, 100, 1, 0);
        check("inv_j32_re", rec_re[32], 185364);
        check("inv_j32_im", rec_im[32], 185364);
        verify_all(7, 1);
`endif

        // LOG2N=4 instance: stage 3, j=2 -> k=2.
        @(negedge clk);
        start4 = 1'b1; stage4 = 2'd3;
        found = 0; cyc = 0;
        while (!found && cyc < 100) begin
            @(negedge clk);
            start4 = 1'b0;
            cyc++;
            if (out_valid4 && out_index4 == 3'd2) found = 1;
        end
        check("n16_found", found, 1);
        check("n16_k2_re", out_real4, 185364);
        check("n16_k2_im", out_imag4, -185364);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
